// File: rtl/cs_pkg.sv
// Shared state codes, opcodes and datapath select encodings for the control sequencer.
package cs_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_IO_IN  = 3'd5;
  localparam logic [2:0] S_IO_OUT = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  // Opcodes 9..15 are undefined and execute as a NOP.
  typedef enum logic [3:0] {
    OP_ALU    = 4'd0,
    OP_ALUI   = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_BRANCH = 4'd4,
    OP_JUMP   = 4'd5,
    OP_IN     = 4'd6,
    OP_OUT    = 4'd7,
    OP_HALT   = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {PC_INC, PC_BR, PC_JMP, PC_REG} pc_sel_e;
  typedef enum logic [1:0] {RD_RD, RD_RT, RD_RA} rd_sel_e;
  typedef enum logic [1:0] {LOC_GPR, LOC_HILO, LOC_RA} loc_sel_e;
  typedef enum logic [1:0] {OPB_REG, OPB_IMM, OPB_DESL, OPB_SHAMT} opb_sel_e;
  typedef enum logic [3:0] {WD_ALU, WD_MEM, WD_IN, WD_IMM, WD_PC} wd_sel_e;

  typedef struct packed {
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       in_req;
    logic       new_out;
    logic [1:0] pc_orig;
    logic [1:0] rd_orig;
    logic [1:0] loc_write;
    logic [1:0] op_b;
    logic [2:0] branch_comp;
    logic [3:0] write_d_sel;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction, I/O handshake and control-word bundle between the sequencer and the datapath.
interface control_sequencer_if;
  logic       run;
  logic [3:0] opcode;
  logic [3:0] operation;
  logic       in_ready;
  logic       out_done;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       in_req;
  logic       new_out;
  logic [1:0] pc_orig;
  logic [1:0] rd_orig;
  logic [1:0] loc_write;
  logic [1:0] op_b;
  logic [2:0] branch_comp;
  logic [3:0] write_d_sel;
  logic [3:0] alu_op;
  logic       busy;
  logic       halted;
  logic       io_timeout;

  modport master (
    input  run, opcode, operation, in_ready, out_done,
    output pc_write, reg_write, mem_write, in_req, new_out, pc_orig, rd_orig,
           loc_write, op_b, branch_comp, write_d_sel, alu_op, busy, halted, io_timeout
  );

  modport slave (
    output run, opcode, operation, in_ready, out_done,
    input  pc_write, reg_write, mem_write, in_req, new_out, pc_orig, rd_orig,
           loc_write, op_b, branch_comp, write_d_sel, alu_op, busy, halted, io_timeout
  );
endinterface

// File: rtl/cs_decode.sv
// Moore control-word decode from {state, latched opcode, operation}; abort marks a timed-out I/O exit.
module cs_decode
  import cs_pkg::*;
(
  input  logic [2:0] state,
  input  logic [3:0] opc,
  input  logic [3:0] operation,
  input  logic       abort,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_EXEC: begin
        ctrl.alu_op = operation;
        case (opc)
          OP_ALU:  ctrl.op_b = OPB_REG;
          OP_ALUI: ctrl.op_b = OPB_IMM;
          OP_LOAD, OP_STORE: ctrl.op_b = OPB_DESL;
          OP_BRANCH: begin
            ctrl.pc_write    = 1'b1;
            ctrl.pc_orig     = PC_BR;
            ctrl.branch_comp = operation[2:0];
          end
          OP_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_orig  = operation[0] ? PC_REG : PC_JMP;
            if (operation[1]) begin
              ctrl.reg_write   = 1'b1;
              ctrl.loc_write   = LOC_RA;
              ctrl.rd_orig     = RD_RA;
              ctrl.write_d_sel = WD_PC;
            end
          end
          OP_IN:   ctrl.in_req  = 1'b1;
          OP_OUT:  ctrl.new_out = 1'b1;
          OP_HALT: ctrl.pc_write = 1'b0;
          default: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_orig  = PC_INC;
          end
        endcase
      end
      S_MEM: begin
        ctrl.op_b = OPB_DESL;
        if (opc == OP_STORE) begin
          ctrl.mem_write = 1'b1;
          ctrl.pc_write  = 1'b1;
        end
      end
      S_IO_IN: ctrl.in_req = 1'b1;
      S_WB: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_orig  = PC_INC;
        // A timed-out wait only advances the PC; the pending register write is dropped.
        if (!abort) begin
          case (opc)
            OP_ALU: begin
              ctrl.reg_write   = 1'b1;
              ctrl.write_d_sel = WD_ALU;
              ctrl.rd_orig     = RD_RD;
              ctrl.loc_write   = LOC_GPR;
            end
            OP_ALUI: begin
              ctrl.reg_write   = 1'b1;
              ctrl.write_d_sel = WD_ALU;
              ctrl.rd_orig     = RD_RT;
              ctrl.loc_write   = LOC_GPR;
            end
            OP_LOAD: begin
              ctrl.reg_write   = 1'b1;
              ctrl.write_d_sel = WD_MEM;
              ctrl.rd_orig     = RD_RT;
              ctrl.loc_write   = LOC_GPR;
            end
            OP_IN: begin
              ctrl.reg_write   = 1'b1;
              ctrl.write_d_sel = WD_IN;
              ctrl.rd_orig     = RD_RT;
              ctrl.loc_write   = LOC_GPR;
            end
            default: ctrl.reg_write = 1'b0;
          endcase
        end
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control FSM: state register, opcode latch and (with CS_IO_TIMEOUT_EN) an I/O wait timeout.
// state | meaning: IDLE wait run | FETCH latch opcode | EXEC execute | MEM memory | WB write back
//       | IO_IN wait in_ready | IO_OUT wait out_done | HALT stopped until rst
module control_sequencer
  import cs_pkg::*;
`ifdef CS_IO_TIMEOUT_EN
#(
  parameter int unsigned IO_TIMEOUT_CYC = 1023,
  parameter int unsigned TMO_W          = 10
)
`endif
(
  input  logic                  clk,
  input  logic                  rst,
  control_sequencer_if.master   bus
);

  logic [2:0] state_q, state_d;
  logic [3:0] opc_q, opc_d;
  logic [2:0] nxt_instr;
  logic       tmo_hit;
  logic       abort;
  ctrl_t      ctrl;

  assign nxt_instr = bus.run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    case (state_q)
      S_IDLE:  if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_EXEC;
        opc_d   = bus.opcode;
      end
      S_EXEC: begin
        case (opc_q)
          OP_ALU, OP_ALUI:   state_d = S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_IN:             state_d = S_IO_IN;
          OP_OUT:            state_d = S_IO_OUT;
          OP_HALT:           state_d = S_HALT;
          default:           state_d = nxt_instr;
        endcase
      end
      S_MEM:    state_d = (opc_q == OP_LOAD) ? S_WB : nxt_instr;
      S_WB:     state_d = nxt_instr;
      S_IO_IN:  if (bus.in_ready || tmo_hit) state_d = S_WB;
      S_IO_OUT: if (bus.out_done || tmo_hit) state_d = S_WB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

`ifdef CS_IO_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic             abort_q, abort_d;
  logic             in_wait, wait_ready;

  // Count is zero outside the wait states, so it is clear on every entry; firing on the last
  // of IO_TIMEOUT_CYC wait cycles flags the timeout as the count reaches the limit.
  always_comb begin
    in_wait    = (state_q == S_IO_IN) || (state_q == S_IO_OUT);
    wait_ready = (state_q == S_IO_IN) ? bus.in_ready : bus.out_done;
    tmo_cnt_d  = in_wait ? tmo_cnt_q + 1'b1 : '0;
    tmo_hit    = in_wait && !wait_ready && (tmo_cnt_q == TMO_W'(IO_TIMEOUT_CYC - 1));
    abort_d    = tmo_hit;
    tmo_flag_d = tmo_flag_q | tmo_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
      abort_q    <= abort_d;
    end
  end

  assign abort          = abort_q;
  assign bus.io_timeout = tmo_flag_q;
`else
  assign tmo_hit        = 1'b0;
  assign abort          = 1'b0;
  assign bus.io_timeout = 1'b0;
`endif

  cs_decode u_decode (
    .state     (state_q),
    .opc       (opc_q),
    .operation (bus.operation),
    .abort     (abort),
    .ctrl      (ctrl)
  );

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.reg_write   = ctrl.reg_write;
  assign bus.mem_write   = ctrl.mem_write;
  assign bus.in_req      = ctrl.in_req;
  assign bus.new_out     = ctrl.new_out;
  assign bus.pc_orig     = ctrl.pc_orig;
  assign bus.rd_orig     = ctrl.rd_orig;
  assign bus.loc_write   = ctrl.loc_write;
  assign bus.op_b        = ctrl.op_b;
  assign bus.branch_comp = ctrl.branch_comp;
  assign bus.write_d_sel = ctrl.write_d_sel;
  assign bus.alu_op      = ctrl.alu_op;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = (state_q == S_HALT);

endmodule
